rv32_wishbone_master: RTL and testbench
=======================================

// Module: rv32_wishbone_master
// PURPOSE
//  Wishbone B4 classic master serving the memory stage for region 0x2xxx_xxxx (peripherals).
//  Accepts one load/store per instruction from the EX/MEM boundary, runs a single bus cycle, and stalls the pipeline until done.
//  Load data drives the memory stage's wishbone read-data input, valid in the cycle stall_o drops, so MEM/WB captures it.
//  Bus timeout and error reporting included.
// PARAMETERS
//  REGION         4'h2  value of addr[31:28] that selects this master
//  TIMEOUT_CYCLES 255   max cycles waiting for ack/err before forced abort (1..65535)
// PORTS
//  clk_i          in   1   clock; all logic rising-edge
//  rst_i          in   1   synchronous, active-high reset
//  req_valid_i    in   1   memory-stage instruction is a load/store this cycle
//  req_write_i    in   1   1 = store, 0 = load
//  req_addr_i     in   32  byte address (memory-stage data address)
//  req_wdata_i    in   32  lane-aligned store data
//  req_sel_i      in   4   byte-lane enables (from memory controller)
//  hold_i         in   1   pipeline frozen by another source; MEM instruction not advancing
//  stall_o        out  1   freeze IF..MEM; MEM/WB must not capture
//  rdata_o        out  32  load data to memory-stage read mux
//  bus_err_o      out  1   1-cycle pulse: access ended by wb_err_i or timeout
//  wb_cyc_o       out  1   Wishbone CYC
//  wb_stb_o       out  1   Wishbone STB
//  wb_we_o        out  1   Wishbone WE
//  wb_adr_o       out  32  Wishbone ADR (word aligned, [1:0]=0)
//  wb_dat_o       out  32  Wishbone DAT master->slave
//  wb_sel_o       out  4   Wishbone SEL
//  wb_dat_i       in   32  Wishbone DAT slave->master
//  wb_ack_i       in   1   Wishbone ACK
//  wb_err_i       in   1   Wishbone ERR
// BEHAVIOUR
//  - hit = req_valid_i & (req_addr_i[31:28] == REGION).
//  - States: IDLE, BUS, DONE. Reset: IDLE; all outputs 0; rdata_o = 0; timeout counter 0.
//  - IDLE: if hit -> latch addr/wdata/sel/we into registers, go BUS; stall_o=1 combinationally this cycle.
//    else stall_o=0.
//  - BUS: wb_cyc_o=wb_stb_o=1, wb_* from latched registers (stable whole cycle); stall_o=1;
//    counter increments each BUS cycle.
//    ack (ack has priority over err in same cycle): rdata_o<=wb_dat_i (load only; stores leave rdata_o unchanged), go DONE.
//    err or counter==TIMEOUT_CYCLES-1: rdata_o<=0, bus_err_o pulses next cycle, go DONE.
//    cyc/stb drop the cycle after ack/err/timeout (no back-to-back cycles).
//  - DONE: stall_o=0, rdata_o stable; stay while hold_i=1; on hold_i=0 -> IDLE (instruction advances this edge).
//    Same request still on req_* in DONE is never reissued.
//  - Latency: 0-wait slave (ack in first BUS cycle) = 2 stall cycles; each wait state adds 1.
//  - Min timeout abort = TIMEOUT_CYCLES BUS cycles; counter cleared on entry to BUS.
//  - hold_i in IDLE/BUS: no effect on bus cycle; a started bus cycle always completes.
//  - Reset mid-BUS: next edge IDLE, cyc/stb low, no bus_err_o pulse; slave late ack in IDLE ignored.
//  - Stray wb_ack_i/wb_err_i outside BUS ignored.
//  - wb_adr_o = {addr[31:2],2'b00}; sub-word placement via wb_sel_o only.
// TESTING
//  - Load 0x2000_0004, slave acks 0-wait with 0xA5A5_1234 -> cyc high 1 cycle, stall_o 2 cycles, rdata_o=0xA5A5_1234 as stall drops.
//  - Store 0x2000_0010 data 0x0000_BE00 sel 4'b0010, 3 wait states -> wb_we_o=1, adr=0x2000_0010, stall_o 5 cycles, bus_err_o=0.
//  - Load, slave never responds, TIMEOUT_CYCLES=8 -> cyc drops after 8 BUS cycles, rdata_o=0, bus_err_o 1-cycle pulse.
//  - Access to 0x1000_0000 or req_valid_i=0 -> no cyc, stall_o=0; ack+err same cycle -> treated as ack, no bus_err_o.
//  - hold_i=1 for 3 cycles in DONE -> stays DONE, single bus cycle only, rdata_o stable; rst_i mid-BUS -> IDLE, cyc=0 next cycle.

Source files
------------

// File: rtl/rv32_wishbone_master.sv
// Wishbone B4 classic master for the memory stage's peripheral region.
// Runs one bus cycle per load/store and stalls the pipeline until it completes.
module rv32_wishbone_master #(
    parameter logic [3:0]  REGION         = 4'h2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_sel_i,
    input  logic        hold_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic [29:0] adr_reg;
    logic [31:0] dat_reg;
    logic [3:0]  sel_reg;
    logic        we_reg;
    logic        cyc_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic hit;
    logic timeout;
    logic unused_addr_bits;

    assign hit              = req_valid_i && (req_addr_i[31:28] == REGION);
    assign timeout          = (count_reg == LAST_COUNT);
    assign unused_addr_bits = ^req_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            count_reg <= '0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            cyc_reg   <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        adr_reg   <= req_addr_i[31:2];
                        dat_reg   <= req_wdata_i;
                        sel_reg   <= req_sel_i;
                        we_reg    <= req_write_i;
                        cyc_reg   <= 1'b1;
                        count_reg <= '0;
                        state_reg <= BUS;
                    end
                end
                BUS: begin
                    count_reg <= count_reg + 16'd1;
                    // ack wins over err when both arrive together
                    if (wb_ack_i) begin
                        if (!we_reg) begin
                            rdata_reg <= wb_dat_i;
                        end
                        cyc_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else if (wb_err_i || timeout) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                        cyc_reg   <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // the same request stays on req_* here; it advances only when hold_i drops
                    if (!hold_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cyc_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o   = (state_reg == BUS) || ((state_reg == IDLE) && hit);
    assign rdata_o   = rdata_reg;
    assign bus_err_o = err_reg;
    assign wb_cyc_o  = cyc_reg;
    assign wb_stb_o  = cyc_reg;
    assign wb_we_o   = we_reg;
    assign wb_adr_o  = {adr_reg, 2'b00};
    assign wb_dat_o  = dat_reg;
    assign wb_sel_o  = sel_reg;

endmodule

// File: tb/tb_rv32_wishbone_master.sv
// Self-checking bench for rv32_wishbone_master: directed vector table, hand-written
// corner sequences and randomized accesses checked against a transaction-level model.
module tb_rv32_wishbone_master;

    localparam int T = 8;
    localparam int R_NONE = 0;
    localparam int R_ACK  = 1;
    localparam int R_ERR  = 2;
    localparam int R_BOTH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_sel = '0;
    logic        hold = 1'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        bus_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_out;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_in = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    int checks = 0;
    int passes = 0;
    logic [31:0] model_rdata = '0;

    rv32_wishbone_master #(
        .REGION(4'h2),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_write_i(req_write),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .req_sel_i(req_sel),
        .hold_i(hold),
        .stall_o(stall),
        .rdata_o(rdata),
        .bus_err_o(bus_err),
        .wb_cyc_o(wb_cyc),
        .wb_stb_o(wb_stb),
        .wb_we_o(wb_we),
        .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_out),
        .wb_sel_o(wb_sel),
        .wb_dat_i(wb_dat_in),
        .wb_ack_i(wb_ack),
        .wb_err_i(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waits;
        int          resp;
        int          hold_n;
        logic [31:0] sdata;
        int          exp_stall;
        int          exp_cyc;
        int          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic valid, input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] sel, input int waits,
                                input int resp, input int hold_n, input logic [31:0] sdata,
                                input int exp_stall, input int exp_cyc, input int exp_err,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.valid = valid; v.write = write; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.waits = waits; v.resp = resp; v.hold_n = hold_n; v.sdata = sdata;
        v.exp_stall = exp_stall; v.exp_cyc = exp_cyc; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Transaction-level reference: how many bus cycles the access lasts and how it ends.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t r;
        int   n;
        r = v;
        if (!(v.valid && v.addr[31:28] == 4'h2)) begin
            r.exp_stall = 0; r.exp_cyc = 0; r.exp_err = 0; r.exp_rdata = prev;
        end else if (v.resp != R_NONE && v.waits + 1 <= T) begin
            n = v.waits + 1;
            r.exp_stall = n + 1;
            r.exp_cyc   = n;
            if (v.resp == R_ERR) begin
                r.exp_err = 1; r.exp_rdata = '0;
            end else begin
                r.exp_err = 0; r.exp_rdata = v.write ? prev : v.sdata;
            end
        end else begin
            r.exp_stall = T + 1; r.exp_cyc = T; r.exp_err = 1; r.exp_rdata = '0;
        end
        return r;
    endfunction

    task automatic run_access(input vec_t v, input string tag);
        int stall_n = 0, cyc_n = 0, err_n = 0, rises = 0, bus_idx = 0, done_n = 0;
        int unstable = 0, rdata_bad = 0;
        logic cyc_prev = 1'b0;
        logic got_rd = 1'b0, got_bus = 1'b0, fin = 1'b0;
        logic [31:0] rd_first = '0, adr_s = '0, dat_s = '0;
        logic [3:0] sel_s = '0;
        logic we_s = 1'b0;
        for (int c = 0; c < 64 && !fin; c++) begin
            @(negedge clk);
            req_valid = v.valid; req_write = v.write; req_addr = v.addr;
            req_wdata = v.wdata; req_sel = v.sel;
            hold = (done_n < v.hold_n);
            wb_ack = 1'b0; wb_err = 1'b0; wb_dat_in = $urandom;
            if (wb_cyc) begin
                bus_idx++;
                if (bus_idx == v.waits + 1) begin
                    if (v.resp == R_ACK || v.resp == R_BOTH) begin
                        wb_ack = 1'b1; wb_dat_in = v.sdata;
                    end
                    if (v.resp == R_ERR || v.resp == R_BOTH) wb_err = 1'b1;
                end
            end
            #1;
            if (stall) stall_n++;
            if (wb_cyc) begin
                cyc_n++;
                if (!cyc_prev) rises++;
                if (!got_bus) begin
                    adr_s = wb_adr; dat_s = wb_dat_out; sel_s = wb_sel; we_s = wb_we; got_bus = 1'b1;
                end else if (wb_adr !== adr_s || wb_dat_out !== dat_s || wb_sel !== sel_s || wb_we !== we_s) begin
                    unstable++;
                end
                if (wb_stb !== 1'b1) unstable++;
            end else if (wb_stb) begin
                unstable++;
            end
            cyc_prev = wb_cyc;
            if (bus_err) err_n++;
            if (!stall) begin
                if (!got_rd) begin
                    rd_first = rdata; got_rd = 1'b1;
                end else if (rdata !== rd_first) begin
                    rdata_bad++;
                end
                done_n++;
                if (!hold) fin = 1'b1;
            end
        end
        wb_ack = 1'b0; wb_err = 1'b0;
        chk({tag, " completes"}, 32'(fin), 32'd1);
        chk({tag, " stall_cycles"}, 32'(stall_n), 32'(v.exp_stall));
        chk({tag, " cyc_cycles"}, 32'(cyc_n), 32'(v.exp_cyc));
        chk({tag, " cyc_rises"}, 32'(rises), (v.exp_cyc > 0) ? 32'd1 : 32'd0);
        chk({tag, " bus_err_pulses"}, 32'(err_n), 32'(v.exp_err));
        chk({tag, " rdata"}, rd_first, v.exp_rdata);
        chk({tag, " rdata_stable"}, 32'(rdata_bad), 32'd0);
        chk({tag, " bus_stable"}, 32'(unstable), 32'd0);
        if (v.exp_cyc > 0) begin
            chk({tag, " wb_adr"}, adr_s, {v.addr[31:2], 2'b00});
            chk({tag, " wb_we"}, 32'(we_s), 32'(v.write));
            chk({tag, " wb_sel"}, 32'(sel_s), 32'(v.sel));
            chk({tag, " wb_dat"}, dat_s, v.wdata);
        end
        $display("txn %s: we=%0d adr=%08h stall=%0d cyc=%0d err=%0d rdata=%08h",
                 tag, v.write, v.addr, stall_n, cyc_n, err_n, rd_first);
    endtask

    initial begin
        tbl[0] = mk(1, 0, 32'h2000_0004, 32'h0, 4'hF, 0, R_ACK, 0, 32'hA5A5_1234, 2, 1, 0, 32'hA5A5_1234);
        tbl[1] = mk(1, 1, 32'h2000_0010, 32'h0000_BE00, 4'b0010, 3, R_ACK, 0, 32'h7777_7777, 5, 4, 0, 32'hA5A5_1234);
        tbl[2] = mk(1, 0, 32'h2000_0020, 32'h0, 4'hF, 0, R_NONE, 0, 32'h0, 9, 8, 1, 32'h0);
        tbl[3] = mk(1, 0, 32'h1000_0000, 32'h0, 4'hF, 0, R_ACK, 0, 32'h1111_1111, 0, 0, 0, 32'h0);
        tbl[4] = mk(0, 0, 32'h2000_0030, 32'h0, 4'hF, 0, R_ACK, 0, 32'h2222_2222, 0, 0, 0, 32'h0);
        tbl[5] = mk(1, 0, 32'h2000_0040, 32'h0, 4'hF, 1, R_BOTH, 0, 32'h1234_5678, 3, 2, 0, 32'h1234_5678);
        tbl[6] = mk(1, 0, 32'h2ABC_DEF7, 32'h0, 4'b1000, 0, R_ACK, 3, 32'hCAFE_F00D, 2, 1, 0, 32'hCAFE_F00D);
        tbl[7] = mk(1, 0, 32'h2000_0050, 32'h0, 4'hF, 2, R_ERR, 0, 32'h3333_3333, 4, 3, 1, 32'h0);
        tbl[8] = mk(1, 1, 32'h2000_0060, 32'hDEAD_0000, 4'b1100, 0, R_ERR, 2, 32'h4444_4444, 2, 1, 1, 32'h0);
        tbl[9] = mk(1, 0, 32'h2000_0070, 32'h0, 4'hF, 7, R_ACK, 0, 32'h0BAD_BEEF, 9, 8, 0, 32'h0BAD_BEEF);

        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset cyc", 32'(wb_cyc), 32'd0);
        chk("reset stb", 32'(wb_stb), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset adr", wb_adr, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_access(tbl[i], $sformatf("vec%0d", i));
            model_rdata = tbl[i].exp_rdata;
        end

        begin : stray_ack
            int cyc_seen = 0, err_seen = 0, stall_seen = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                req_valid = 1'b0; hold = 1'b0;
                wb_ack = 1'b1; wb_err = 1'b1; wb_dat_in = 32'h1111_1111;
                #1;
                if (wb_cyc) cyc_seen++;
                if (bus_err) err_seen++;
                if (stall) stall_seen++;
            end
            @(negedge clk);
            wb_ack = 1'b0; wb_err = 1'b0;
            #1;
            if (bus_err) err_seen++;
            chk("stray cyc", 32'(cyc_seen), 32'd0);
            chk("stray stall", 32'(stall_seen), 32'd0);
            chk("stray bus_err", 32'(err_seen), 32'd0);
            chk("stray rdata", rdata, model_rdata);
            $display("txn stray_ack: rdata=%08h", rdata);
        end

        begin : reset_mid_bus
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0080; req_sel = 4'hF;
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("rstbus cyc_before", 32'(wb_cyc), 32'd1);
            rst = 1'b1; req_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            wb_ack = 1'b1; wb_err = 1'b1; wb_dat_in = 32'hDEAD_BEEF;
            #1;
            chk("rstbus cyc_after", 32'(wb_cyc), 32'd0);
            chk("rstbus stall_after", 32'(stall), 32'd0);
            chk("rstbus bus_err_after", 32'(bus_err), 32'd0);
            @(negedge clk);
            wb_ack = 1'b0; wb_err = 1'b0;
            #1;
            chk("rstbus late_ack_rdata", rdata, 32'd0);
            chk("rstbus late_ack_cyc", 32'(wb_cyc), 32'd0);
            chk("rstbus late_ack_err", 32'(bus_err), 32'd0);
            model_rdata = '0;
            $display("txn reset_mid_bus: cyc=%0d rdata=%08h", wb_cyc, rdata);
        end

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.valid = ($urandom_range(0, 7) != 0);
            v.addr  = $urandom;
            if ($urandom_range(0, 5) != 0) v.addr[31:28] = 4'h2;
            v.write  = 1'($urandom_range(0, 1));
            v.wdata  = $urandom;
            v.sel    = 4'($urandom);
            v.waits  = int'($urandom_range(0, 9));
            v.resp   = int'($urandom_range(0, 3));
            v.hold_n = int'($urandom_range(0, 2));
            v.sdata  = $urandom;
            v = model(v, model_rdata);
            run_access(v, $sformatf("rnd%0d", i));
            model_rdata = v.exp_rdata;
        end

        @(negedge clk);
        req_valid = 1'b0; hold = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
